// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - Hack CPU program counter with hold/inc/load and a call/return stack.
// Optional feature macro: PC_SATURATE_EN (saturate at all-ones instead of wrapping).
module pc_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             push_en;
  logic             at_max;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] pc_next_seq;
  logic [CW-1:0]    cnt_m1;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic             unused_cnt_bits;

  assign at_max   = &pc_q;
  assign pc_plus1 = pc_q + WIDTH'(1);

`ifdef PC_SATURATE_EN
  assign pc_next_seq = at_max ? pc_q : pc_plus1;
`else
  assign pc_next_seq = pc_plus1;
`endif

  // Stack slots are addressed by the low bits of the count; upper count bits only gate full/empty.
  assign cnt_m1          = cnt_q - CW'(1);
  assign top_idx         = cnt_m1[AW-1:0];
  assign push_idx        = cnt_q[AW-1:0];
  assign unused_cnt_bits = ^{cnt_m1, cnt_q};

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    err_d   = err_q;
    push_en = 1'b0;
    if (en) begin
      if (ret) begin
        if (cnt_q != '0) begin
          pc_d  = stack_q[top_idx];
          cnt_d = cnt_m1;
        end else begin
          err_d = 1'b1;
        end
      end else if (call) begin
        if (cnt_q == FULL_CNT) begin
          err_d = 1'b1;
        end else begin
          push_en = 1'b1;
          pc_d    = load_val;
          cnt_d   = cnt_q + CW'(1);
        end
      end else if (load) begin
        pc_d = load_val;
      end else if (inc) begin
        pc_d  = pc_next_seq;
        ovf_d = at_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  // Storage needs no reset: entries above the count are never read.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      stack_q[push_idx] <= pc_next_seq;
    end
  end

  assign out         = pc_q;
  assign overflow    = ovf_q;
  assign stack_empty = (cnt_q == '0);
  assign stack_full  = (cnt_q == FULL_CNT);
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - Directed and randomized checks of pc_unit against a queue-based model.
module tb_pc_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             inc = 1'b0;
  logic             load = 1'b0;
  logic             call = 1'b0;
  logic             ret = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] out;
  logic             overflow;
  logic             stack_empty;
  logic             stack_full;
  logic             stack_err;

  pc_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .inc        (inc),
    .load       (load),
    .call       (call),
    .ret        (ret),
    .load_val   (load_val),
    .out        (out),
    .overflow   (overflow),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_pc  = 0;
  int m_ovf = 0;
  int m_err = 0;
  int m_stk[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int succ(input int v);
`ifdef PC_SATURATE_EN
    return (v == MAXV) ? MAXV : v + 1;
`else
    return (v + 1) % (MAXV + 1);
`endif
  endfunction

  task automatic model_step();
    if (reset) begin
      m_pc = 0; m_ovf = 0; m_err = 0; m_stk.delete();
    end else begin
      m_ovf = 0;
      if (!en) begin
      end else if (ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else m_err = 1;
      end else if (call) begin
        if (m_stk.size() == DEPTH) m_err = 1;
        else begin
          m_stk.push_back(succ(m_pc));
          m_pc = int'(load_val);
        end
      end else if (load) begin
        m_pc = int'(load_val);
      end else if (inc) begin
        if (m_pc == MAXV) m_ovf = 1;
        m_pc = succ(m_pc);
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".out"},   int'(out),         m_pc);
    check({tag, ".ovf"},   int'(overflow),    m_ovf);
    check({tag, ".empty"}, int'(stack_empty), int'(m_stk.size() == 0));
    check({tag, ".full"},  int'(stack_full),  int'(m_stk.size() == DEPTH));
    check({tag, ".err"},   int'(stack_err),   m_err);
  endtask

  task automatic step(input logic r, input logic e, input logic i, input logic l,
                      input logic c, input logic rt, input int lv, input string tag);
    reset = r; en = e; inc = i; load = l; call = c; ret = rt;
    load_val = WIDTH'(lv);
    @(posedge clk);
    model_step();
    #1;
    compare_model(tag);
  endtask

  initial begin
    // reset and simple increments
    step(1, 0, 0, 0, 0, 0, 0, "rst");
    check("rst_out", int'(out), 0);
    check("rst_empty", int'(stack_empty), 1);
    check("rst_err", int'(stack_err), 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 1, 0, 0, 0, 0, "inc3");
      check("inc3_out", int'(out), k);
      check("inc3_ovf", int'(overflow), 0);
    end

    // increment past all-ones
    step(0, 1, 0, 1, 0, 0, 'hFFFE, "ldfffe");
    step(0, 1, 1, 0, 0, 0, 0, "wrap1");
    check("wrap1_out", int'(out), 'hFFFF);
    check("wrap1_ovf", int'(overflow), 0);
    step(0, 1, 1, 0, 0, 0, 0, "wrap2");
`ifdef PC_SATURATE_EN
    check("wrap2_out", int'(out), 'hFFFF);
`else
    check("wrap2_out", int'(out), 0);
`endif
    check("wrap2_ovf", int'(overflow), 1);
    step(0, 1, 0, 0, 0, 0, 0, "wrap3");
    check("wrap3_ovf", int'(overflow), 0);

    // single call/return
    step(0, 1, 0, 1, 0, 0, 'h0010, "ld10");
    step(0, 1, 0, 0, 1, 0, 'h0200, "call1");
    check("call1_out", int'(out), 'h0200);
    check("call1_empty", int'(stack_empty), 0);
    step(0, 1, 0, 0, 0, 1, 0, "ret1");
    check("ret1_out", int'(out), 'h0011);
    check("ret1_empty", int'(stack_empty), 1);

    // fill stack, overflow it, drain it
    step(1, 0, 0, 0, 0, 0, 0, "rst2");
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 1, 0, 'h0100 + k, "call5");
    check("call5_out", int'(out), 'h0103);
    check("call5_full", int'(stack_full), 1);
    check("call5_err", int'(stack_err), 1);
    begin
      int exp_ret[4] = '{'h0103, 'h0102, 'h0101, 'h0001};
      for (int k = 0; k < 4; k++) begin
        step(0, 1, 0, 0, 0, 1, 0, "ret4");
        check("ret4_out", int'(out), exp_ret[k]);
      end
    end
    check("ret4_empty", int'(stack_empty), 1);

    // return on empty stack is sticky
    step(1, 0, 0, 0, 0, 0, 0, "rst3");
    step(0, 1, 0, 1, 0, 0, 'h0042, "ld42");
    step(0, 1, 0, 0, 0, 1, 0, "reterr");
    check("reterr_out", int'(out), 'h0042);
    check("reterr_err", int'(stack_err), 1);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 0, 0, "sticky");
    check("sticky_err", int'(stack_err), 1);

    // stall and reset priority
    step(0, 1, 0, 1, 0, 0, 'h0005, "ld5");
    step(0, 0, 1, 1, 0, 0, 'h0777, "stall");
    check("stall_out", int'(out), 'h0005);
    step(1, 1, 0, 0, 1, 0, 'h0300, "rstcall");
    check("rstcall_out", int'(out), 0);
    check("rstcall_empty", int'(stack_empty), 1);
    check("rstcall_err", int'(stack_err), 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int lv;
      int sel;
      sel = int'($urandom_range(0, 7));
      lv  = (sel == 0) ? MAXV - int'($urandom_range(0, 2)) : int'($urandom_range(0, MAXV));
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0),
           lv, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
